keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Scan scheduler for a 4x4 active-low matrix keypad.
- Contains its own tick divider (default 1 kHz at a 100 MHz clk) and steps the row drive on that tick.
- Debounces press and release, then presents a 4-bit key code to the downstream adder/display logic on a valid/ready handshake.
- Replaces free-running divided clocks: all logic runs on clk and uses a one-cycle tick enable.

Parameters:
- TICK_DIV, 100000, clk cycles per scan tick; legal range 4..2^28-1.
- DEBOUNCE_TICKS, 4, consecutive matching ticks needed to confirm a press or a release; legal range 1..15.
- REPEAT_DELAY, 500, ticks from press confirm to first auto-repeat; used only with TYPEMATIC_EN.
- REPEAT_RATE, 100, ticks between later auto-repeats; used only with TYPEMATIC_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous.
- row_out  output  4  row drive, active-low, exactly one bit low at any time.
- key_code  output  4  confirmed key: row*4 + column index.
- key_valid  output  1  key_code holds an unconsumed key.
- key_ready  input  1  consumer accepts the key when key_valid && key_ready.
- overflow  output  1  sticky: a confirmed key was dropped because key_valid was already pending.
- scan_tick  output  1  one-cycle tick strobe, for debug and sharing.

Behaviour:
- Reset (rst=1 at a posedge) sets: row_out=4'b1110, key_code=0, key_valid=0, overflow=0, scan_tick=0, tick counter=0, state=SCAN, debounce/repeat counters=0, synchronizer=4'b1111. Reset mid-debounce or mid-hold abandons the key; no partial output.
- Synchronizer: col_in passes through 2 flops (col_s) before use.
- Tick counter: 28-bit, counts 0..TICK_DIV-1 and wraps to 0. scan_tick=1 for exactly the cycle the counter equals TICK_DIV-1.
- All state decisions happen only on scan_tick cycles, except the handshake.
- Sampling rule: col_s is sampled on the tick. The row being sampled has been driven for a full tick period.
- SCAN, on tick:
  - If col_s != 4'hF: latch the current row index and the lowest-index low column (col 0 = bit 0), set dbcnt=1, go to PRESS_DB.
  - Otherwise rotate row_out left by 1 (1110->1101->1011->0111->1110).
  - If DEBOUNCE_TICKS=1, confirm immediately (same action as the PRESS_DB confirm).
- PRESS_DB: row_out is held. On tick:
  - If col_s equals the latched pattern: dbcnt++. When dbcnt reaches DEBOUNCE_TICKS, confirm the key and go to HOLD with relcnt=0.
  - Mismatch: rotate row, go to SCAN.
- Confirm / push:
  - If key_valid=0, or key_valid && key_ready in the same cycle: key_code <= row*4+col and key_valid <= 1, visible the cycle after the confirming tick.
  - Otherwise the new key is dropped and overflow <= 1.
- HOLD: row_out is held. On tick:
  - col_s == 4'hF: relcnt++. When relcnt reaches DEBOUNCE_TICKS, rotate row and go to SCAN.
  - Any low column: relcnt=0.
  - No further key is emitted while in HOLD, except under TYPEMATIC_EN.
- Handshake:
  - key_valid falls the cycle after key_valid && key_ready, unless a push lands in that same cycle (then it stays 1 with the new code).
  - key_code is stable while key_valid=1.
- Overflow is cleared only by rst.
- Multiple keys in one row: the lowest column wins. Keys in other rows are ignored until the return to SCAN.

Optional Feature:
- Macro KEYPAD_TYPEMATIC_EN.
- Defined: HOLD keeps a repeat counter cleared on HOLD entry. It pushes the same key_code after REPEAT_DELAY ticks, then every REPEAT_RATE ticks while the key stays pressed. Pushes follow the same overflow rule. The repeat counter resets whenever relcnt becomes non-zero.
- Undefined: the repeat logic and the REPEAT_* parameters have no effect; exactly one push per press.

Test Plan (simulation uses TICK_DIV=10, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2):
- Reset, idle columns (col_in=4'hF) -> scan_tick every 10 clk; row_out cycles 1110,1101,1011,0111,1110 with one step per tick; key_valid stays 0.
- Hold key row2/col1 stable, key_ready=1 -> after 3 matching ticks key_code=9 and key_valid pulses one cycle; no second push until 3 released ticks have passed and the key is pressed again.
- Bounce: col low for 1 tick, then high on the next -> return to SCAN; key_valid never asserts.
- key_ready=0, press key 0, release, then press key 15 -> key_code stays 0 with key_valid=1; overflow=1. Raise key_ready -> key_valid drops the next cycle.
- Assert rst during PRESS_DB -> next cycle row_out=1110, key_valid=0, overflow=0, state=SCAN.
- With KEYPAD_TYPEMATIC_EN, hold key 5 for 12 ticks after confirm, key_ready=1 -> pushes at confirm, +5, +7, +9 and +11 ticks; without the macro, only 1 push.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: tick divider, row stepping, press/release debounce, valid/ready key out.
// Optional auto-repeat while a key is held: define KEYPAD_TYPEMATIC_EN.
module keypad_scan_ctrl #(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    output logic       scan_tick
);

    localparam logic [27:0] TICK_MAX = 28'(TICK_DIV - 1);
    localparam logic [3:0]  DB_N     = 4'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {SCAN, PRESS_DB, HOLD} state_t;

    state_t      state, state_d;
    logic [27:0] tick_cnt;
    logic [3:0]  sync1, col_s;
    logic [1:0]  row_idx, row_idx_d;
    logic [1:0]  key_col, key_col_d, low_col;
    logic [3:0]  pat, pat_d;
    logic [3:0]  dbcnt, dbcnt_d;
    logic [3:0]  relcnt, relcnt_d;
    logic        idle_cols;
    logic        push;
    logic [3:0]  push_code;

`ifdef KEYPAD_TYPEMATIC_EN
    localparam logic [15:0] REP_DLY = 16'(REPEAT_DELAY);
    localparam logic [15:0] REP_RT  = 16'(REPEAT_RATE);
    logic [15:0] rep_cnt, rep_cnt_d;
    logic        rep_first, rep_first_d;
`endif

    assign scan_tick = (tick_cnt == TICK_MAX);
    assign row_out   = ~(4'b0001 << row_idx);
    assign idle_cols = (col_s == 4'hF);

    // Lowest-index low column wins when several keys share a row.
    always_comb begin
        low_col = 2'd3;
        casez (col_s)
            4'b???0: low_col = 2'd0;
            4'b??01: low_col = 2'd1;
            4'b?011: low_col = 2'd2;
            default: low_col = 2'd3;
        endcase
    end

    always_comb begin
        state_d   = state;
        row_idx_d = row_idx;
        key_col_d = key_col;
        pat_d     = pat;
        dbcnt_d   = dbcnt;
        relcnt_d  = relcnt;
        push      = 1'b0;
        push_code = {row_idx, key_col};
        if (scan_tick) begin
            unique case (state)
                SCAN: begin
                    if (!idle_cols) begin
                        pat_d     = col_s;
                        key_col_d = low_col;
                        dbcnt_d   = 4'd1;
                        if (DB_N == 4'd1) begin
                            state_d   = HOLD;
                            relcnt_d  = '0;
                            push      = 1'b1;
                            push_code = {row_idx, low_col};
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end else begin
                        row_idx_d = row_idx + 2'd1;
                    end
                end
                PRESS_DB: begin
                    if (col_s == pat) begin
                        dbcnt_d = dbcnt + 4'd1;
                        if (dbcnt + 4'd1 == DB_N) begin
                            state_d  = HOLD;
                            relcnt_d = '0;
                            push     = 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        row_idx_d = row_idx + 2'd1;
                    end
                end
                HOLD: begin
                    if (idle_cols) begin
                        relcnt_d = relcnt + 4'd1;
                        if (relcnt + 4'd1 == DB_N) begin
                            state_d   = SCAN;
                            row_idx_d = row_idx + 2'd1;
                        end
                    end else begin
                        relcnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

`ifdef KEYPAD_TYPEMATIC_EN
        rep_cnt_d   = rep_cnt;
        rep_first_d = rep_first;
        if (state_d == HOLD && state != HOLD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (scan_tick && state == HOLD) begin
            if (idle_cols) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (rep_cnt + 16'd1 == (rep_first ? REP_DLY : REP_RT)) begin
                push        = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            sync1     <= 4'hF;
            col_s     <= 4'hF;
            state     <= SCAN;
            row_idx   <= '0;
            key_col   <= '0;
            pat       <= 4'hF;
            dbcnt     <= '0;
            relcnt    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            tick_cnt <= scan_tick ? '0 : tick_cnt + 28'd1;
            sync1    <= col_in;
            col_s    <= sync1;
            state    <= state_d;
            row_idx  <= row_idx_d;
            key_col  <= key_col_d;
            pat      <= pat_d;
            dbcnt    <= dbcnt_d;
            relcnt   <= relcnt_d;
            // A push into a slot being drained this cycle is accepted, not dropped.
            if (push) begin
                if (!key_valid || key_ready) begin
                    key_code  <= push_code;
                    key_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_TYPEMATIC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_d;
            rep_first <= rep_first_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, tick-level reference model,
// directed scenarios then randomized presses and consumer back-pressure.
module tb_keypad_scan_ctrl;

    localparam int TD = 10;
    localparam int DB = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overflow;
    logic        scan_tick;
    logic [15:0] pressed;

    int          total = 0;
    int          bad = 0;
    int          rises = 0;
    int          ticks = 0;
    logic        prev_v = 1'b0;

    int          m_cnt, m_row, m_phase, m_db, m_rel, m_held;
    logic [3:0]  m_pat, m_key, m_code, m_s1, m_s2;
    logic        m_valid, m_ovf;

    keypad_scan_ctrl #(
        .TICK_DIV(TD),
        .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .col_in(col_in),
        .row_out(row_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .overflow(overflow),
        .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] cols_seen(input logic [15:0] p, input int r);
        logic [3:0] c;
        c = 4'hF;
        for (int k = 0; k < 4; k++)
            if (p[r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic int lowest(input logic [3:0] c);
        for (int k = 0; k < 4; k++)
            if (!c[k]) return k;
        return 0;
    endfunction

    // Physical matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row_out[r] === 1'b0) col_in = col_in & cols_seen(pressed, r);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: one call per clock edge, decisions only on tick edges.
    task automatic model_edge();
        logic [3:0] cs, cin;
        logic       push, tick;
        if (rst) begin
            m_cnt = 0; m_row = 0; m_phase = 0; m_db = 0; m_rel = 0; m_held = 0;
            m_pat = 4'hF; m_key = 4'h0; m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
            m_valid = 1'b0; m_ovf = 1'b0;
            return;
        end
        cin  = cols_seen(pressed, m_row);
        cs   = m_s2;
        tick = (m_cnt == TD - 1);
        push = 1'b0;
        if (tick) begin
            case (m_phase)
                0: begin
                    if (cs != 4'hF) begin
                        m_pat = cs;
                        m_key = 4'(m_row * 4 + lowest(cs));
                        m_db = 1;
                        m_phase = 1;
                    end else m_row = (m_row + 1) % 4;
                end
                1: begin
                    if (cs == m_pat) begin
                        m_db++;
                        if (m_db == DB) begin
                            m_phase = 2; m_rel = 0; m_held = 0; push = 1'b1;
                        end
                    end else begin
                        m_phase = 0;
                        m_row = (m_row + 1) % 4;
                    end
                end
                default: begin
                    if (cs == 4'hF) begin
                        m_held = 0;
                        m_rel++;
                        if (m_rel == DB) begin
                            m_phase = 0;
                            m_row = (m_row + 1) % 4;
                        end
                    end else begin
                        m_rel = 0;
                        m_held++;
`ifdef KEYPAD_TYPEMATIC_EN
                        if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0))
                            push = 1'b1;
`endif
                    end
                end
            endcase
        end
        if (push) begin
            if (!m_valid || key_ready) begin
                m_code = m_key;
                m_valid = 1'b1;
            end else m_ovf = 1'b1;
        end else if (m_valid && key_ready) m_valid = 1'b0;
        m_cnt = tick ? 0 : m_cnt + 1;
        m_s2 = m_s1;
        m_s1 = cin;
    endtask

    task automatic cyc();
        logic [3:0] er;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        er = 4'hF;
        er[m_row] = 1'b0;
        chk("row_out", row_out, er);
        chk("scan_tick", scan_tick, (m_cnt == TD - 1));
        chk("key_valid", key_valid, m_valid);
        chk("key_code", key_code, m_code);
        chk("overflow", overflow, m_ovf);
        if (key_valid === 1'b1 && prev_v !== 1'b1) rises++;
        if (scan_tick === 1'b1) ticks++;
        prev_v = key_valid;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_rise(input string tag, input int limit);
        int r0, n;
        r0 = rises;
        n = 0;
        while (rises == r0 && n < limit) begin
            cyc();
            n++;
        end
        chk(tag, (rises != r0), 1);
    endtask

    task automatic wait_tick(input string tag, input int limit);
        int n;
        n = 0;
        while (scan_tick !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        chk(tag, scan_tick, 1);
    endtask

    function automatic int cur_row();
        for (int r = 0; r < 4; r++)
            if (row_out[r] === 1'b0) return r;
        return 0;
    endfunction

    initial begin
        int r0, k, k2, hold, gap;
        rst = 1'b1;
        key_ready = 1'b1;
        pressed = '0;
        run(2);
        chk("rst_row", row_out, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tick", scan_tick, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b0;

        ticks = 0;
        run(50);
        chk("idle_ticks", ticks, 5);
        chk("idle_row", row_out, 4'b1101);
        chk("idle_rises", rises, 0);

        pressed = 16'(1 << 9);
        wait_rise("k9_timeout", 200);
        chk("k9_code", key_code, 9);
        pressed = '0;
        cyc();
        chk("k9_pulse", key_valid, 0);
        run(19);
        pressed = 16'(1 << 9);
        r0 = rises;
        run(40);
        chk("k9_no_repush", rises - r0, 0);
        pressed = '0;
        run(60);
        pressed = 16'(1 << 9);
        wait_rise("k9_again_timeout", 200);
        chk("k9_again_code", key_code, 9);
        pressed = '0;
        run(60);

        wait_tick("bounce_tick", 40);
        cyc();
        pressed = 16'(1 << (cur_row() * 4 + 2));
        r0 = rises;
        run(10);
        pressed = '0;
        run(60);
        chk("bounce_rises", rises - r0, 0);

        key_ready = 1'b0;
        pressed = 16'h0001;
        wait_rise("ovf_k0_timeout", 200);
        chk("ovf_k0_code", key_code, 0);
        pressed = '0;
        run(60);
        pressed = 16'h8000;
        for (int n = 0; n < 200 && overflow !== 1'b1; n++) cyc();
        chk("ovf_set", overflow, 1);
        chk("ovf_code_kept", key_code, 0);
        chk("ovf_valid_kept", key_valid, 1);
        pressed = '0;
        key_ready = 1'b1;
        cyc();
        chk("ovf_drain", key_valid, 0);
        chk("ovf_sticky", overflow, 1);
        run(60);

        wait_tick("rstdb_tick", 40);
        cyc();
        pressed = 16'(1 << (cur_row() * 4 + 1));
        run(11);
        rst = 1'b1;
        pressed = '0;
        cyc();
        chk("rstdb_row", row_out, 4'b1110);
        chk("rstdb_valid", key_valid, 0);
        chk("rstdb_ovf", overflow, 0);
        rst = 1'b0;
        run(40);

        pressed = 16'(1 << 5);
        wait_rise("k5_timeout", 200);
        chk("k5_code", key_code, 5);
        r0 = rises;
        run(120);
`ifdef KEYPAD_TYPEMATIC_EN
        chk("k5_repeats", rises - r0, 4);
`else
        chk("k5_repeats", rises - r0, 0);
`endif
        pressed = '0;
        run(60);

        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(15, 0);
            k2 = $urandom_range(15, 0);
            hold = $urandom_range(160, 5);
            gap = $urandom_range(90, 5);
            pressed = 16'(1 << k);
            if ($urandom_range(3, 0) == 0) pressed[k2] = 1'b1;
            repeat (hold) begin
                key_ready = ($urandom_range(3, 0) != 0);
                cyc();
            end
            pressed = '0;
            repeat (gap) begin
                key_ready = ($urandom_range(3, 0) != 0);
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
